// File: rtl/wb_regfile_if.sv
// Bus between the MEM/WB pipeline register, the decode read ports and the
// writeback/register-file block.
interface wb_regfile_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic            memtoreg_wb;
  logic            regwrite_wb;
  logic [XLEN-1:0] readdata_wb;
  logic [XLEN-1:0] alures_wb;
  logic [AW-1:0]   rd_wb;
  logic [2:0]      func3_wb;
  logic [AW-1:0]   rs1_id;
  logic [AW-1:0]   rs2_id;
  logic [XLEN-1:0] rdata1_id;
  logic [XLEN-1:0] rdata2_id;
  logic [XLEN-1:0] wb_data;
  logic            wb_we;
  logic            load_err;

  modport master (
    output memtoreg_wb, regwrite_wb, readdata_wb, alures_wb, rd_wb, func3_wb,
           rs1_id, rs2_id,
    input  rdata1_id, rdata2_id, wb_data, wb_we, load_err
  );

  modport slave (
    input  memtoreg_wb, regwrite_wb, readdata_wb, alures_wb, rd_wb, func3_wb,
           rs1_id, rs2_id,
    output rdata1_id, rdata2_id, wb_data, wb_we, load_err
  );
endinterface

// File: rtl/wb_regfile.sv
// Writeback stage: load alignment/extension, 32-entry integer register file,
// two decode read ports with same-cycle write-through bypass, sticky load error.

// One decode read port: x0 forcing and writeback bypass over the array value.
module wb_rd_port #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic [AW-1:0]   rs,
  input  logic [XLEN-1:0] arr_q,
  input  logic            byp_en,
  input  logic [AW-1:0]   byp_rd,
  input  logic [XLEN-1:0] byp_data,
  output logic [XLEN-1:0] rdata
);
  always_comb begin
    rdata = arr_q;
    if (rs == '0)
      rdata = '0;
    else if (byp_en && (byp_rd == rs))
      rdata = byp_data;
  end
endmodule

module wb_regfile #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  wb_regfile_if.slave bus
);
  localparam int AW  = $clog2(NREG);
  localparam int NRD = 2;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // x0 has no storage; the array starts at index 1.
  logic [XLEN-1:0] regs [1:NREG-1];

  logic [1:0]      off;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_data;
  logic            misaligned;
  logic            illegal;
  logic            bad;
  logic [XLEN-1:0] wb_data;
  logic            wb_we;
  logic            load_err_q;

  // ---------------------------------------------------------------------------
  // Load extraction and error classification
  // ---------------------------------------------------------------------------
  assign off     = bus.alures_wb[1:0];
  assign ld_byte = bus.readdata_wb[{off, 3'b000} +: 8];
  assign ld_half = bus.readdata_wb[{off[1], 4'b0000} +: 16];

  always_comb begin
    ld_data    = bus.readdata_wb;
    misaligned = 1'b0;
    illegal    = 1'b0;
    unique case (bus.func3_wb)
      F3_LB:  ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      F3_LBU: ld_data = {{(XLEN-8){1'b0}}, ld_byte};
      F3_LH: begin
        ld_data    = {{(XLEN-16){ld_half[15]}}, ld_half};
        misaligned = off[0];
      end
      F3_LHU: begin
        ld_data    = {{(XLEN-16){1'b0}}, ld_half};
        misaligned = off[0];
      end
      F3_LW:  misaligned = (off != 2'b00);
      default: illegal = 1'b1;
    endcase
  end

  assign bad     = bus.memtoreg_wb & (misaligned | illegal);
  assign wb_data = bus.memtoreg_wb ? ld_data : bus.alures_wb;
  assign wb_we   = bus.regwrite_wb & (bus.rd_wb != '0) & ~bad;

  assign bus.wb_data  = wb_data;
  assign bus.wb_we    = wb_we;
  assign bus.load_err = load_err_q;

  // ---------------------------------------------------------------------------
  // Register array and sticky error flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NREG; i++) regs[i] <= '0;
    end else if (wb_we) begin
      regs[bus.rd_wb] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   load_err_q <= 1'b0;
    else if (bad) load_err_q <= 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------
  logic [NRD-1:0][AW-1:0]   rs_vec;
  logic [NRD-1:0][XLEN-1:0] arr_vec;
  logic [NRD-1:0][XLEN-1:0] rdata_vec;
  logic                     byp_en;

  assign rs_vec = {bus.rs2_id, bus.rs1_id};
  // Bypass is held off in reset so the ports show zeros immediately.
  assign byp_en = wb_we & rst_n;

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    always_comb begin
      arr_vec[p] = '0;
      if (rs_vec[p] != '0) arr_vec[p] = regs[rs_vec[p]];
    end

    wb_rd_port #(.XLEN(XLEN), .AW(AW)) u_port (
      .rs       (rs_vec[p]),
      .arr_q    (arr_vec[p]),
      .byp_en   (byp_en),
      .byp_rd   (bus.rd_wb),
      .byp_data (wb_data),
      .rdata    (rdata_vec[p])
    );
  end

  assign bus.rdata1_id = rdata_vec[0];
  assign bus.rdata2_id = rdata_vec[1];
endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: stimulus pushes model expectations, a
// negedge monitor pops and compares against the DUT outputs.
module tb_wb_regfile;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_regfile_if #(.XLEN(32), .AW(5)) bus ();

  wb_regfile #(.XLEN(32), .NREG(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [31:0] data;
    logic        we;
    logic [31:0] r1;
    logic [31:0] r2;
    logic        err;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mregs [32];
  logic        merr;
  int          vectors = 0;
  int          miscompares = 0;

  // Reference model of the load rules, written from the instruction semantics.
  function automatic void ref_load(input logic [2:0] f3, input logic [31:0] rdat,
                                   input logic [1:0] off, output logic [31:0] val,
                                   output logic bad_ld);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'((rdat >> (8 * off)) & 32'hFF);
    h = 16'((rdat >> (16 * (off / 2))) & 32'hFFFF);
    val = rdat;
    bad_ld = 1'b0;
    case (f3)
      3'd0: val = {{24{b[7]}}, b};
      3'd4: val = {24'h0, b};
      3'd1: begin val = {{16{h[15]}}, h}; bad_ld = (off % 2) != 0; end
      3'd5: begin val = {16'h0, h};       bad_ld = (off % 2) != 0; end
      3'd2: bad_ld = (off != 0);
      default: bad_ld = 1'b1;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
    merr = 1'b0;
  endtask

  function automatic logic [31:0] ref_read(input logic [4:0] a, input logic we,
                                           input logic [4:0] rd, input logic [31:0] d);
    if (a == 0) return 32'h0;
    if (we && rd == a) return d;
    return mregs[a];
  endfunction

  task automatic drive(input logic m2r, input logic rw, input logic [31:0] rdat,
                       input logic [31:0] alu, input logic [4:0] rd,
                       input logic [2:0] f3, input logic [4:0] a1, input logic [4:0] a2);
    logic [31:0] ld;
    logic        bad_ld;
    logic        bad;
    exp_t        e;
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.memtoreg_wb = m2r;  bus.regwrite_wb = rw;
    bus.readdata_wb = rdat; bus.alures_wb   = alu;
    bus.rd_wb = rd; bus.func3_wb = f3; bus.rs1_id = a1; bus.rs2_id = a2;
    ref_load(f3, rdat, alu[1:0], ld, bad_ld);
    bad    = m2r && bad_ld;
    e.data = m2r ? ld : alu;
    e.we   = rw && (rd != 0) && !bad;
    e.r1   = ref_read(a1, e.we, rd, e.data);
    e.r2   = ref_read(a2, e.we, rd, e.data);
    e.err  = merr;
    q.push_back(e);
    if (bad) merr = 1'b1;
    if (e.we) mregs[rd] = e.data;
  endtask

  // One cycle held in reset with idle writeback inputs.
  task automatic reset_cycle(input logic [4:0] a1, input logic [4:0] a2);
    exp_t e;
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.memtoreg_wb = 1'b0; bus.regwrite_wb = 1'b0;
    bus.alures_wb = 32'h0; bus.rd_wb = 5'd0; bus.func3_wb = 3'd0;
    bus.rs1_id = a1; bus.rs2_id = a2;
    model_reset();
    e.data = 32'h0; e.we = 1'b0; e.r1 = 32'h0; e.r2 = 32'h0; e.err = 1'b0;
    q.push_back(e);
  endtask

  task automatic idle(input logic [4:0] a1, input logic [4:0] a2);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 3'd0, a1, a2);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: one popped expectation per cycle, sampled mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        vectors++;
        chk("wb_data",   bus.wb_data,   e.data);
        chk("wb_we",     32'(bus.wb_we), 32'(e.we));
        chk("rdata1_id", bus.rdata1_id, e.r1);
        chk("rdata2_id", bus.rdata2_id, e.r2);
        chk("load_err",  32'(bus.load_err), 32'(e.err));
      end
    end
  end

  localparam logic [31:0] RD = 32'h80F17F02;

  initial begin
    bus.memtoreg_wb = 1'b0; bus.regwrite_wb = 1'b0; bus.readdata_wb = 32'h0;
    bus.alures_wb = 32'h0; bus.rd_wb = 5'd0; bus.func3_wb = 3'd0;
    bus.rs1_id = 5'd0; bus.rs2_id = 5'd0;
    model_reset();
    repeat (2) @(posedge clk);

    // Reset state on both ports
    for (int i = 0; i < 32; i++) idle(5'(i), 5'(31 - i));

    // Async reset mid-run clears x5 immediately
    drive(1'b0, 1'b1, 32'h0, 32'h1234, 5'd5, 3'd0, 5'd5, 5'd0);
    idle(5'd5, 5'd5);
    reset_cycle(5'd5, 5'd5);
    idle(5'd5, 5'd5);

    // ALU write with same-cycle bypass, then array read
    drive(1'b0, 1'b1, 32'h0, 32'hDEADBEEF, 5'd7, 3'd0, 5'd7, 5'd7);
    idle(5'd7, 5'd7);

    // Load extraction
    drive(1'b1, 1'b1, RD, 32'h3, 5'd10, 3'b000, 5'd10, 5'd10);
    drive(1'b1, 1'b1, RD, 32'h3, 5'd10, 3'b100, 5'd10, 5'd10);
    drive(1'b1, 1'b1, RD, 32'h1, 5'd10, 3'b000, 5'd10, 5'd10);
    drive(1'b1, 1'b1, RD, 32'h2, 5'd10, 3'b001, 5'd10, 5'd10);
    drive(1'b1, 1'b1, RD, 32'h0, 5'd10, 3'b101, 5'd10, 5'd10);
    drive(1'b1, 1'b1, RD, 32'h0, 5'd10, 3'b010, 5'd10, 5'd10);
    idle(5'd10, 5'd0);

    // Write to x0 is discarded
    drive(1'b0, 1'b1, 32'h0, 32'hFFFFFFFF, 5'd0, 3'd0, 5'd0, 5'd0);
    idle(5'd0, 5'd0);

    // Bad loads never write and set the sticky flag
    drive(1'b0, 1'b1, 32'h0, 32'h11, 5'd9, 3'd0, 5'd9, 5'd9);
    drive(1'b1, 1'b1, RD, 32'h2, 5'd9, 3'b010, 5'd9, 5'd9);
    for (int i = 0; i < 10; i++) idle(5'd9, 5'd9);
    drive(1'b1, 1'b1, RD, 32'h1, 5'd9, 3'b001, 5'd9, 5'd9);
    drive(1'b1, 1'b1, RD, 32'h0, 5'd9, 3'b011, 5'd9, 5'd9);
    idle(5'd9, 5'd9);

    // Error flag independent of regwrite and rd
    reset_cycle(5'd0, 5'd0);
    drive(1'b1, 1'b0, RD, 32'h1, 5'd0, 3'b001, 5'd0, 5'd0);
    idle(5'd0, 5'd0);

    // Back-to-back writes track the latest value
    drive(1'b0, 1'b1, 32'h0, 32'h1, 5'd3, 3'd0, 5'd3, 5'd4);
    drive(1'b0, 1'b1, 32'h0, 32'h2, 5'd3, 3'd0, 5'd3, 5'd4);
    drive(1'b0, 1'b1, 32'h0, 32'h3, 5'd4, 3'd0, 5'd3, 5'd4);
    idle(5'd3, 5'd4);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 79) == 0) begin
        reset_cycle(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      end else begin
        drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), $urandom(),
              $urandom(), 5'($urandom_range(0, 31)),
              ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 2)),
              5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      end
    end

    // Drain with a bounded wait
    for (int t = 0; t < 10 && q.size() != 0; t++) @(posedge clk);
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/wb_regfile.md
# wb_regfile

Writeback stage and integer register file for the five-stage pipeline. It sits directly downstream of the MEM/WB pipeline register and consumes its outputs. It selects ALU result or load data, and aligns and sign- or zero-extends load data by `func3`. It writes the 32×32 register file and serves the two decode-stage read ports with same-cycle write-through bypass. A sticky flag records any misaligned or illegal load reaching writeback.

## Interface
- `XLEN`, default 32: data width.
- `NREG`, default 32: register count; address width is 5.
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: asynchronous active-low reset.
- `memtoreg_wb`  in  1: 1 = write load data, 0 = write `alures_wb`.
- `regwrite_wb`  in  1: register write request.
- `readdata_wb`  in  32: word-aligned word returned by data memory.
- `alures_wb`  in  32: ALU result; for loads this is the byte address, bits [1:0] select the lane.
- `rd_wb`  in  5: destination register.
- `func3_wb`  in  3: load type.
- `rs1_id`, `rs2_id`  in  5: decode-stage read addresses.
- `rdata1_id`, `rdata2_id`  out  32: read data (combinational).
- `wb_data`  out  32: value being written back (combinational; also feeds EX forwarding).
- `wb_we`  out  1: qualified write enable actually applied this cycle.
- `load_err`  out  1: sticky misaligned/illegal-load flag, registered.

## Operation
- Load extraction, used only when `memtoreg_wb=1`. `off` = `alures_wb[1:0]`.
  - 000 LB: byte `readdata_wb[8*off+7:8*off]`, sign-extended.
  - 100 LBU: same byte, zero-extended.
  - 001 LH: half `readdata_wb[16*off[1]+15:16*off[1]]`, sign-extended.
  - 101 LHU: same half, zero-extended.
  - 010 LW: full word.
  - 011, 110, 111: illegal; data = full word.
- Misaligned load: LH/LHU with `off[0]=1`, or LW with `off!=0`.
- `bad` = `memtoreg_wb` & (misaligned | illegal).
- `wb_data` = `memtoreg_wb` ? extracted : `alures_wb`.
- `wb_we` = `regwrite_wb` & (`rd_wb`≠0) & ~`bad`.
  - A bad load never writes the register file.
  - A write to x0 is discarded.
- Register file write: on posedge `clk` with `wb_we`, `regs[rd_wb]` ← `wb_data`.
- Read port n, for n = 1, 2:
  - If `rsn_id`=0, output 0.
  - Else if `wb_we` & (`rd_wb`=`rsn_id`), output `wb_data` (write-through bypass, so there is no WB→ID hazard).
  - Else output `regs[rsn_id]`.
- Both ports may read the same register; both bypass identically.
- `load_err`:
  - Set on any posedge where `bad`=1.
  - Remains set until reset; no other clear.
- x0 is never stored; reads of x0 return 0 regardless of content.

## Timing
- Reset (`rst_n`=0, asynchronous, immediate):
  - All registers 1..31 ← 0.
  - `load_err` ← 0.
  - Writes are blocked while `rst_n`=0.
  - `rdata*` reflect zeros combinationally after reset asserts.
- A reset mid-stream discards the write of that cycle.
- Deassertion is sampled on the next rising edge; the first write can occur on that edge.
- Write latency: 1 edge. The value is visible through the bypass in the same cycle, and from the array in the following cycle.
- The `wb_data` and `wb_we` paths are purely combinational from the MEM/WB register outputs.
- `load_err` asserts one edge after a `bad` cycle.
- Simultaneous events:
  - Read and write to the same register in the same cycle: the read returns the new value.
  - Bad load with `rd_wb`=0: `load_err` is still set.
  - `regwrite_wb`=0 with `memtoreg_wb`=1 and a misaligned address: `load_err` is still set. The error flag does not depend on `regwrite_wb`.
- No stall/handshake: the block accepts one writeback every cycle.

## Test plan
- Reset, then read all 32 registers on both ports → all 0. Assert `rst_n`=0 mid-run after writing x5=0x1234 → `rdata1_id`(rs1=5)=0 immediately.
- ALU write x7 ← 0xDEADBEEF (`memtoreg`=0, `regwrite`=1), rs1=rs2=7 in the same cycle → both 0xDEADBEEF via bypass; next cycle still 0xDEADBEEF from the array.
- Loads from `readdata`=0x80F17F02:
  - LB off=3 → 0xFFFFFF80.
  - LBU off=3 → 0x00000080.
  - LB off=1 → 0x0000007F.
  - LH off=2 → 0xFFFF80F1.
  - LHU off=0 → 0x00007F02.
  - LW off=0 → 0x80F17F02.
- Write to x0 with 0xFFFFFFFF → `wb_we`=0, rs1=0 reads 0 both that cycle and the next.
- LW with off=2 into x9 (x9 previously 0x11) → `wb_we`=0, x9 stays 0x11, `load_err`=1 after the edge and still 1 ten cycles later. Repeat with LH off=1 and with func3=011 → same result.
- Back-to-back writes x3←1, x3←2, x4←3 on consecutive cycles, reading rs1=3, rs2=4 each cycle → the read values track the latest value each cycle, with no stale value.
